bus_arbiter12: RTL

- Controls the shared 12-bit processor bus. Arbitrates among NUM_SRC drivers and produces their one-hot tri-state enables (ctrl), one enable per 12-bit tri-state buffer.
- Captures the resolved bus value into a registered output for downstream consumers (register file, ALU operand latch).
- Inserts a one-cycle turnaround between grants, so two buffers never drive the bus in the same cycle.

---
 rtl/bus_arbiter12_if.sv | 22 ++
 rtl/bus_arbiter12.sv | 129 ++++++++++++
 2 files changed

// File: rtl/bus_arbiter12_if.sv
// Bundle of request, bus and capture signals between the bus arbiter and the bus sources.
interface bus_arbiter12_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0] req;
  logic [11:0]        bus_in;
  logic [NUM_SRC-1:0] ctrl;
  logic [11:0]        data_out;
  logic               data_valid;
  logic [2:0]         src_id;
  logic               busy;

  modport master (
    input  req, bus_in,
    output ctrl, data_out, data_valid, src_id, busy
  );

  modport slave (
    output req, bus_in,
    input  ctrl, data_out, data_valid, src_id, busy
  );
endinterface

// File: rtl/bus_arbiter12.sv
// Round-robin arbiter for the shared 12-bit bus with a one-cycle turnaround and registered capture.
// Define BUS_ARB_TIMEOUT_EN to force a release after MAX_GRANT captured words.
module bus_arbiter12 #(
  parameter int NUM_SRC   = 4,
  parameter int MAX_GRANT = 8
) (
  input  logic            clock,
  input  logic            resetn,
  bus_arbiter12_if.master bus
);
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t             state, state_next;
  logic [2:0]         grant_idx, grant_next;
  logic [2:0]         last, last_next;
  logic [NUM_SRC-1:0] ctrl_q, ctrl_next;
  logic [11:0]        data_q;
  logic               valid_q;
  logic [2:0]         src_q;
  logic               capture;
  logic               limit_hit;
  logic [7:0]         req8;
  logic [2:0]         cand;
  logic               pick_found;
  logic [2:0]         pick_idx;

  if (NUM_SRC < 2 || NUM_SRC > 8 || MAX_GRANT < 1) begin : g_param_check
    $error("bus_arbiter12: NUM_SRC must be 2..8 and MAX_GRANT at least 1");
  end

  assign req8 = 8'(bus.req);

  // Round-robin search: first requester strictly after the last winner, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = 3'((int'(last) + i) % NUM_SRC);
      if (!pick_found && req8[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_GRANT + 1);
  logic [CW-1:0] word_cnt;

  // Held at zero outside GRANT, so it is clear on every entry to GRANT.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)              word_cnt <= '0;
    else if (state != GRANT)  word_cnt <= '0;
    else if (capture)         word_cnt <= word_cnt + CW'(1);
  end

  assign limit_hit = (word_cnt == CW'(MAX_GRANT - 1));
`else
  assign limit_hit = 1'b0;
`endif

  // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    state_next = state;
    grant_next = grant_idx;
    last_next  = last;
    ctrl_next  = ctrl_q;
    capture    = 1'b0;
    case (state)
      IDLE, TURN: begin
        state_next = IDLE;
        ctrl_next  = '0;
        if (pick_found) begin
          state_next = GRANT;
          grant_next = pick_idx;
          last_next  = pick_idx;
          ctrl_next  = NUM_SRC'(1) << pick_idx;
        end
      end
      GRANT: begin
        if (req8[grant_idx]) begin
          capture = 1'b1;
          // The limiting capture and the release share one edge.
          if (limit_hit) begin
            state_next = TURN;
            ctrl_next  = '0;
          end
        end else begin
          state_next = TURN;
          ctrl_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
        ctrl_next  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      grant_idx <= '0;
      last      <= 3'(NUM_SRC - 1);
      ctrl_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      src_q     <= '0;
    end else begin
      state     <= state_next;
      grant_idx <= grant_next;
      last      <= last_next;
      ctrl_q    <= ctrl_next;
      valid_q   <= capture;
      if (capture) begin
        data_q <= bus.bus_in;
        src_q  <= grant_idx;
      end
    end
  end

  assign bus.ctrl       = ctrl_q;
  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.src_id     = src_q;
  assign bus.busy       = (state != IDLE);
endmodule
